// File: rtl/axi_txn_limiter_pkg.sv
// axi_txn_limiter_pkg: shared AXI field widths and counter type for the transaction limiter.
package axi_txn_limiter_pkg;
    localparam int AXI_ID_W    = 16;
    localparam int AXI_ADDR_W  = 64;
    localparam int AXI_LEN_W   = 8;
    localparam int AXI_SIZE_W  = 3;
    localparam int AXI_DATA_W  = 512;
    localparam int AXI_STRB_W  = 64;
    localparam int AXI_RESP_W  = 2;
    localparam int AXI_RUSER_W = 1;
    localparam int CNT_W       = 8;

    typedef logic [CNT_W-1:0] cnt_t;

    function automatic cnt_t to_cnt(input int n);
        return cnt_t'(n);
    endfunction
endpackage

// File: rtl/axi_bus_t.sv
// axi_bus_t: AXI bus bundle; modports are named for the agent on the far side of the port.
interface axi_bus_t;
    import axi_txn_limiter_pkg::*;
    logic [AXI_ID_W-1:0]    awid;
    logic [AXI_ADDR_W-1:0]  awaddr;
    logic [AXI_LEN_W-1:0]   awlen;
    logic [AXI_SIZE_W-1:0]  awsize;
    logic                   awvalid, awready;
    logic [AXI_DATA_W-1:0]  wdata;
    logic [AXI_STRB_W-1:0]  wstrb;
    logic                   wlast, wvalid, wready;
    logic [AXI_ID_W-1:0]    bid;
    logic [AXI_RESP_W-1:0]  bresp;
    logic                   bvalid, bready;
    logic [AXI_ID_W-1:0]    arid;
    logic [AXI_ADDR_W-1:0]  araddr;
    logic [AXI_LEN_W-1:0]   arlen;
    logic [AXI_SIZE_W-1:0]  arsize;
    logic                   arvalid, arready;
    logic [AXI_ID_W-1:0]    rid;
    logic [AXI_DATA_W-1:0]  rdata;
    logic [AXI_RESP_W-1:0]  rresp;
    logic [AXI_RUSER_W-1:0] ruser;
    logic                   rlast, rvalid, rready;

    modport master (
        input  awid, awaddr, awlen, awsize, awvalid, output awready,
        input  wdata, wstrb, wlast, wvalid, output wready,
        output bid, bresp, bvalid, input bready,
        input  arid, araddr, arlen, arsize, arvalid, output arready,
        output rid, rdata, rresp, ruser, rlast, rvalid, input rready
    );
    modport slave (
        output awid, awaddr, awlen, awsize, awvalid, input awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input  bid, bresp, bvalid, output bready,
        output arid, araddr, arlen, arsize, arvalid, input arready,
        input  rid, rdata, rresp, ruser, rlast, rvalid, output rready
    );
endinterface

// File: rtl/axi_credit_ctr.sv
// axi_credit_ctr: 8-bit saturating up/down counter; flags a decrement attempted at zero.
module axi_credit_ctr
    import axi_txn_limiter_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic inc_i,
    input  logic dec_i,
    output cnt_t cnt_o,
    output logic uflow_o
);
    cnt_t cnt_q, cnt_d;

    always_comb cnt_d = (inc_i && !dec_i && cnt_q != '1) ? cnt_q + cnt_t'(1) :
                        (dec_i && !inc_i && cnt_q != '0) ? cnt_q - cnt_t'(1) : cnt_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;

    assign uflow_o = dec_i && !inc_i && cnt_q == '0;
    assign cnt_o   = cnt_q;
endmodule

// File: rtl/axi_txn_limiter.sv
// axi_txn_limiter: caps outstanding AR/AW bursts, admits W only against accepted AWs,
// and offers a drain/idle handshake for quiescing the application.
module axi_txn_limiter
    import axi_txn_limiter_pkg::*;
#(
    parameter int MAX_RD = 16,
    parameter int MAX_WR = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    axi_bus_t.master        axi_s,
    axi_bus_t.slave         axi_m,
    input  logic            drain,
    output logic            idle,
    output logic [CNT_W-1:0] rd_outstanding,
    output logic [CNT_W-1:0] wr_outstanding,
    output logic            err
);
    localparam cnt_t RD_LIM = to_cnt(MAX_RD);
    localparam cnt_t WR_LIM = to_cnt(MAX_WR);

    cnt_t rd_cnt, wr_cnt, w_cred;
    logic ar_ok, aw_ok, w_ok;
    logic ar_hs, aw_hs, wl_hs, r_hs, b_hs;
    logic [2:0] uf;
    logic err_q, err_d;

    assign ar_ok = !drain && rd_cnt < RD_LIM;
    assign aw_ok = !drain && wr_cnt < WR_LIM;
    assign w_ok  = w_cred != '0;

    // Reset forces every handshake-initiating signal low so nothing is exchanged mid-reset.
    assign axi_m.arvalid = rst_n && axi_s.arvalid && ar_ok;
    assign axi_s.arready = rst_n && axi_m.arready && ar_ok;
    assign axi_m.awvalid = rst_n && axi_s.awvalid && aw_ok;
    assign axi_s.awready = rst_n && axi_m.awready && aw_ok;
    assign axi_m.wvalid  = rst_n && axi_s.wvalid && w_ok;
    assign axi_s.wready  = rst_n && axi_m.wready && w_ok;
    assign axi_s.bvalid  = rst_n && axi_m.bvalid;
    assign axi_m.bready  = axi_s.bready;
    assign axi_s.rvalid  = rst_n && axi_m.rvalid;
    assign axi_m.rready  = axi_s.rready;

    assign axi_m.arid   = axi_s.arid;
    assign axi_m.araddr = axi_s.araddr;
    assign axi_m.arlen  = axi_s.arlen;
    assign axi_m.arsize = axi_s.arsize;
    assign axi_m.awid   = axi_s.awid;
    assign axi_m.awaddr = axi_s.awaddr;
    assign axi_m.awlen  = axi_s.awlen;
    assign axi_m.awsize = axi_s.awsize;
    assign axi_m.wdata  = axi_s.wdata;
    assign axi_m.wstrb  = axi_s.wstrb;
    assign axi_m.wlast  = axi_s.wlast;
    assign axi_s.bid    = axi_m.bid;
    assign axi_s.bresp  = axi_m.bresp;
    assign axi_s.rid    = axi_m.rid;
    assign axi_s.rdata  = axi_m.rdata;
    assign axi_s.rresp  = axi_m.rresp;
    assign axi_s.ruser  = axi_m.ruser;
    assign axi_s.rlast  = axi_m.rlast;

    assign ar_hs = axi_m.arvalid && axi_m.arready;
    assign aw_hs = axi_m.awvalid && axi_m.awready;
    assign wl_hs = axi_m.wvalid && axi_m.wready && axi_s.wlast;
    assign r_hs  = axi_m.rvalid && axi_s.rready && axi_m.rlast;
    assign b_hs  = axi_m.bvalid && axi_s.bready;

    axi_credit_ctr u_rd_cnt (.clk, .rst_n, .inc_i(ar_hs), .dec_i(r_hs),  .cnt_o(rd_cnt), .uflow_o(uf[0]));
    axi_credit_ctr u_wr_cnt (.clk, .rst_n, .inc_i(aw_hs), .dec_i(b_hs),  .cnt_o(wr_cnt), .uflow_o(uf[1]));
    axi_credit_ctr u_w_cred (.clk, .rst_n, .inc_i(aw_hs), .dec_i(wl_hs), .cnt_o(w_cred), .uflow_o(uf[2]));

    assign err_d = err_q || (|uf);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;

    assign err            = err_q;
    assign idle           = rd_cnt == '0 && wr_cnt == '0 && w_cred == '0;
    assign rd_outstanding = rd_cnt;
    assign wr_outstanding = wr_cnt;
endmodule

// File: doc/axi_txn_limiter.md
# axi_txn_limiter

Outstanding-transaction limiter and quiesce gate placed directly upstream of the AXI register slice on each application memory path. It counts AR/AW bursts in flight, stalls new requests once a per-direction limit is reached, and admits W beats only for already accepted write bursts. It also provides a drain/idle handshake so the shell can quiesce an application before revocation or reconfiguration.

## Interface
Parameters:
- MAX_RD, 16, maximum read bursts outstanding (AR accepted, final R beat not yet returned); legal range 1..255
- MAX_WR, 16, maximum write bursts outstanding (AW accepted, B not yet returned); legal range 1..255

Ports:
- clk  in  1  single clock for all logic
- rst_n  in  1  asynchronous, active-low reset
- axi_s  axi_bus_t.master modport  -  upstream (application) side; id 16, addr 64, len 8, size 3, data 512, strb 64, resp 2, ruser 1
- axi_m  axi_bus_t.slave modport  -  downstream side, toward the register slice
- drain  in  1  level; when high, blocks new AW/AR
- idle  out  1  high when rd_cnt, wr_cnt and w_cred are all 0
- rd_outstanding  out  8  current rd_cnt
- wr_outstanding  out  8  current wr_cnt
- err  out  1  sticky; response arrived with its counter at 0

## Operation
- All payload fields pass through unchanged. The block gates only valid/ready signals.
- AR:
  - ar_ok = !drain && rd_cnt < MAX_RD
  - axi_m.arvalid = axi_s.arvalid && ar_ok
  - axi_s.arready = axi_m.arready && ar_ok
- AW: same form, using aw_ok = !drain && wr_cnt < MAX_WR.
- W:
  - w_ok = w_cred > 0
  - axi_m.wvalid = axi_s.wvalid && w_ok
  - axi_s.wready = axi_m.wready && w_ok
- B and R: pure pass-through (valid forward, ready backward).
- rd_cnt:
  - +1 on an AR handshake at axi_m.
  - −1 on an R handshake with rlast.
  - Both in the same cycle: no change.
- wr_cnt: +1 on an AW handshake, −1 on a B handshake. Both in the same cycle: no change.
- w_cred: +1 on an AW handshake, −1 on a W handshake with wlast. Both in the same cycle: no change.
- Invariant: w_cred ≤ wr_cnt ≤ MAX_WR.
- Underflow (decrement with counter at 0, no simultaneous increment):
  - Counter holds at 0.
  - err sets and stays set until reset.
  - The beat is still forwarded.
- drain:
  - Affects AW/AR only. W beats for accepted bursts, B and R continue.
  - idle asserts once in-flight traffic completes.
  - Deasserting drain reopens AW/AR on the same cycle.
- There is no state machine; behaviour is three up/down counters plus gating.

## Timing
- Zero-cycle combinational path on every channel; no added latency. The downstream register slice breaks the timing path.
- Counters and err update on the rising clk edge after the qualifying handshake. Gating therefore reflects the counts as of the previous edge.
- Limit boundary: the handshake that brings rd_cnt to MAX_RD completes. From the next cycle axi_m.arvalid is 0 until a final R beat is accepted. The cycle after that beat, arvalid may rise.
- W beats presented in the same cycle as the first AW handshake are held. They are admitted from the next cycle, when w_cred = 1.
- Reset (rst_n low, asynchronous):
  - Counters = 0, err = 0, idle = 1, rd/wr_outstanding = 0.
  - All axi_m valids, all axi_s readies, axi_s.bvalid and axi_s.rvalid are forced to 0 while rst_n is low.
- Reset mid-burst clears all counts. Upstream and downstream are reset together, so no orphan responses are expected. Any that arrive set err.

## Structure
- AXI field widths (id 16, addr 64, len 8, size 3, data 512, strb 64, resp 2) belong in the shared AOS package. Do not redeclare them locally.
- One sub-module: axi_credit_ctr, an 8-bit saturating up/down counter with inc, dec and an underflow output. It is instantiated three times (rd_cnt, wr_cnt, w_cred). err is the OR of the underflow outputs, registered sticky.

## Test plan
- Read limit: MAX_RD=4, issue 6 single-beat ARs with R held off → exactly 4 ARs reach axi_m and rd_outstanding=4. Return one rlast → the 5th AR is forwarded the cycle after.
- Write ordering: AW len=3 and 4 W beats presented in the same cycle → W held for 1 cycle, then 4 beats pass. w_cred returns to 0 after wlast, and wr_cnt=1 until B is returned.
- Simultaneous events: rd_cnt=2, AR handshake and rlast handshake in the same cycle → rd_cnt stays 2. Repeat for AW+B and AW+wlast.
- Drain: 3 reads and 2 writes outstanding, assert drain → no new AR/AW accepted. idle rises exactly the cycle after the last B/R completes. Deassert drain → AR accepted the same cycle.
- Underflow: inject B with wr_cnt=0 → B forwarded, wr_cnt stays 0, err=1 and stays 1 until rst_n pulse.
- Async reset with 5 reads outstanding → all counters 0 and idle=1 immediately, before the next clk edge. All valids/readies at 0 while rst_n is low.
